// File: rtl/fsm_moore_seq_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_moore_seq_counter_if
// Brief    : Control and status bundle for the Moore sequence counter.
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_moore_seq_counter_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 go;
    logic                 dir;
    logic                 pause;
    logic                 abort;
    logic [CNT_WIDTH-1:0] count;
    logic                 done;
    logic                 busy;
    logic [1:0]           state_o;

    modport master (
        output go, dir, pause, abort,
        input  count, done, busy, state_o
    );

    modport slave (
        input  go, dir, pause, abort,
        output count, done, busy, state_o
    );
endinterface
`default_nettype wire

// File: rtl/fsm_moore_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_moore_seq_counter
// Brief    : Prescaled Moore up/down sequence counter with pause, abort,
//            latched go request and optional auto-restart.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_moore_seq_counter #(
    parameter int CLK_DIV      = 1500000,
    parameter int CNT_WIDTH    = 4,
    parameter int MAX_COUNT    = 15,
    parameter int DONE_TICKS   = 1,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fsm_moore_seq_counter_if.slave bus
);
    localparam int c_div_w  = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int c_done_w = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_count = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] c_max       = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);
    localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_done_w-1:0]  c_done_last = c_done_w'(DONE_TICKS - 1);

    logic [c_div_w-1:0]   r_div_cnt;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_go_pend;
    logic                 r_dir_q;
    logic [c_done_w-1:0]  r_done_cnt;

    logic                 w_tick;
    logic [CNT_WIDTH-1:0] w_end;

    assign w_tick = (r_div_cnt == c_div_last);
    assign w_end  = r_dir_q ? '0 : c_max;

    // Free-running prescaler: state changes and abort never disturb tick phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_go_pend  <= 1'b0;
            r_dir_q    <= 1'b0;
            r_done_cnt <= '0;
        end else if (bus.abort) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_go_pend <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_count <= '0;
                    if (w_tick && (r_go_pend || bus.go)) begin
                        r_state   <= c_st_count;
                        r_dir_q   <= bus.dir;
                        r_count   <= bus.dir ? c_max : '0;
                        r_go_pend <= 1'b0;
                    end else if (bus.go) begin
                        r_go_pend <= 1'b1;
                    end
                end
                c_st_count: begin
                    r_go_pend <= 1'b0;
                    if (w_tick && !bus.pause) begin
                        if (r_count == w_end) begin
                            r_state    <= c_st_done;
                            r_done_cnt <= '0;
                        end else if (r_dir_q) begin
                            r_count <= r_count - c_one;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                end
                c_st_done: begin
                    r_go_pend <= 1'b0;
                    if (w_tick) begin
                        r_done_cnt <= r_done_cnt + c_done_w'(1);
                        if (r_done_cnt == c_done_last) begin
                            // Auto-restart reuses the captured direction, not the live dir input
                            if (AUTO_RESTART) begin
                                r_state <= c_st_count;
                                r_count <= r_dir_q ? c_max : '0;
                            end else begin
                                r_state <= c_st_idle;
                                r_count <= '0;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_count   <= '0;
                    r_go_pend <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = r_count;
    assign bus.done    = (r_state == c_st_done);
    assign bus.busy    = (r_state == c_st_count);
    assign bus.state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fsm_moore_seq_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_moore_seq_counter
// Brief    : Self-checking bench for two counter configurations sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_moore_seq_counter;
    localparam int MAXC = 5;
    localparam int DT   = 2;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0, dir = 1'b0, pause = 1'b0, abort = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsm_moore_seq_counter_if #(.CNT_WIDTH(W)) ifa ();
    fsm_moore_seq_counter_if #(.CNT_WIDTH(W)) ifb ();

    assign ifa.go = go;  assign ifa.dir = dir;  assign ifa.pause = pause;  assign ifa.abort = abort;
    assign ifb.go = go;  assign ifb.dir = dir;  assign ifb.pause = pause;  assign ifb.abort = abort;

    fsm_moore_seq_counter #(
        .CLK_DIV(4), .CNT_WIDTH(W), .MAX_COUNT(MAXC), .DONE_TICKS(DT), .AUTO_RESTART(1'b0)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    fsm_moore_seq_counter #(
        .CLK_DIV(1), .CNT_WIDTH(W), .MAX_COUNT(MAXC), .DONE_TICKS(DT), .AUTO_RESTART(1'b1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference: phase (0 idle, 1 counting, 2 done), position along the run, ticks left in done
    typedef struct {
        int div;
        int st;
        int pos;
        bit pend;
        bit dq;
        int dleft;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, int cdiv, bit autor,
                                   bit r, bit g, bit d, bit p, bit a);
        mdl_t n;
        bit   t;
        n = m;
        if (r) begin
            n = '{0, 0, 0, 1'b0, 1'b0, 0};
            return n;
        end
        t     = (m.div == cdiv - 1);
        n.div = t ? 0 : m.div + 1;
        if (a) begin
            n.st = 0; n.pos = 0; n.pend = 1'b0;
        end else if (m.st == 0) begin
            if (t && (m.pend || g)) begin
                n.st = 1; n.dq = d; n.pos = 0; n.pend = 1'b0;
            end else if (g) begin
                n.pend = 1'b1;
            end
        end else if (m.st == 1) begin
            if (t && !p) begin
                if (m.pos == MAXC) begin
                    n.st = 2; n.dleft = DT;
                end else begin
                    n.pos = m.pos + 1;
                end
            end
        end else begin
            if (t) begin
                n.dleft = m.dleft - 1;
                if (n.dleft == 0) begin
                    n.st  = autor ? 1 : 0;
                    n.pos = 0;
                end
            end
        end
        return n;
    endfunction

    function automatic int exp_vec(mdl_t m);
        logic [3:0] c;
        logic [1:0] s;
        c = (m.st == 0) ? 4'd0 : (m.dq ? 4'(MAXC - m.pos) : 4'(m.pos));
        s = 2'(m.st);
        return int'({c, (m.st == 2), (m.st == 1), s});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        ma = mstep(ma, 4, 1'b0, rst, go, dir, pause, abort);
        mb = mstep(mb, 1, 1'b1, rst, go, dir, pause, abort);
        #1;
        check("model_a", int'({ifa.count, ifa.done, ifa.busy, ifa.state_o}), exp_vec(ma));
        check("model_b", int'({ifb.count, ifb.done, ifb.busy, ifb.state_o}), exp_vec(mb));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (ifa.state_o != 2'd0 && k < 100) begin
            step_clk();
            k++;
        end
        check("wait_idle", int'(ifa.state_o), 0);
    endtask

    typedef struct {
        bit rst;
        bit go;
        int n;
        int ecount;
        int estate;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int q[$];
        int busy_cnt, pl, k;
        bit paused, seen;

        // Reset, 1-clk go between ticks, full up run with fixed per-value dwell
        tbl.push_back('{1'b1, 1'b0, 3, 0, 0});
        tbl.push_back('{1'b0, 1'b1, 1, 0, 0});
        tbl.push_back('{1'b0, 1'b0, 2, 0, 0});
        tbl.push_back('{1'b0, 1'b0, 4, 0, 1});
        tbl.push_back('{1'b0, 1'b0, 4, 1, 1});
        tbl.push_back('{1'b0, 1'b0, 4, 2, 1});
        tbl.push_back('{1'b0, 1'b0, 4, 3, 1});
        tbl.push_back('{1'b0, 1'b0, 4, 4, 1});
        tbl.push_back('{1'b0, 1'b0, 4, 5, 1});
        tbl.push_back('{1'b0, 1'b0, 8, 5, 2});
        tbl.push_back('{1'b0, 1'b0, 4, 0, 0});

        ma = '{0, 0, 0, 1'b0, 1'b0, 0};
        mb = ma;

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            go  = tbl[i].go;
            for (int j = 0; j < tbl[i].n; j++) begin
                step_clk();
                check("tbl_count", int'(ifa.count), tbl[i].ecount);
                check("tbl_state", int'(ifa.state_o), tbl[i].estate);
                check("tbl_done", int'(ifa.done), int'(tbl[i].estate == 2));
            end
        end

        // Reset mid-run, then first tick lands on the 4th clk after release
        go = 1'b1; step_clk(); go = 1'b0;
        repeat (10) step_clk();
        rst = 1'b1;
        step_clk();
        check("rst_count", int'(ifa.count), 0);
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_done", int'(ifa.done), 0);
        check("rst_state", int'(ifa.state_o), 0);
        repeat (2) step_clk();
        rst = 1'b0;
        go  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step_clk();
            check("rst_pre_tick", int'(ifa.state_o), 0);
        end
        step_clk();
        check("rst_first_tick", int'(ifa.state_o), 1);
        go = 1'b0;
        abort = 1'b1; step_clk(); abort = 1'b0;

        // Down count: dir toggles after start must not matter
        dir = 1'b1; go = 1'b1; step_clk(); go = 1'b0;
        k = 0;
        while (!ifa.done && k < 100) begin
            dir = ifa.busy ? 1'($urandom) : 1'b1;
            step_clk();
            if (ifa.busy && (q.size() == 0 || q[$] != int'(ifa.count))) q.push_back(int'(ifa.count));
            k++;
        end
        dir = 1'b0;
        check("down_len", q.size(), 6);
        for (int i = 0; i < q.size() && i < 6; i++) check("down_seq", q[i], MAXC - i);
        wait_idle();

        // Pause 12 clks at count 2 stretches the run by 12 clks
        go = 1'b1; step_clk(); go = 1'b0;
        busy_cnt = 0; pl = 0; paused = 1'b0; seen = 1'b0; k = 0;
        while (k < 200) begin
            pause = (pl > 0);
            step_clk();
            if (pl > 0) pl--;
            if (ifa.busy) begin busy_cnt++; seen = 1'b1; end
            if (!paused && ifa.busy && ifa.count == 4'd2) begin pl = 12; paused = 1'b1; end
            if (seen && !ifa.busy) break;
            k++;
        end
        pause = 1'b0;
        check("pause_busy_len", busy_cnt, 6 * 4 + 12);
        wait_idle();

        // Abort on the very edge that would advance from count 3
        go = 1'b1; step_clk(); go = 1'b0;
        k = 0;
        while (!(ma.st == 1 && ma.pos == 3) && k < 100) begin step_clk(); k++; end
        k = 0;
        while (ma.div != 3 && k < 10) begin step_clk(); k++; end
        check("abort_pre_count", int'(ifa.count), 3);
        abort = 1'b1; step_clk(); abort = 1'b0;
        check("abort_state", int'(ifa.state_o), 0);
        check("abort_count", int'(ifa.count), 0);
        go = 1'b1; abort = 1'b1; step_clk(); go = 1'b0; abort = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step_clk();
            check("abort_go_idle", int'(ifa.state_o), 0);
        end

        // Auto-restart config: two done clks then reload to 0 and counting
        go = 1'b1; step_clk(); go = 1'b0;
        k = 0;
        while (!ifb.done && k < 50) begin step_clk(); k++; end
        check("b_done_seen", int'(ifb.done), 1);
        step_clk();
        check("b_done_2nd", int'(ifb.done), 1);
        step_clk();
        check("b_restart_busy", int'(ifb.busy), 1);
        check("b_restart_count", int'(ifb.count), 0);
        go = 1'b1; repeat (3) step_clk(); go = 1'b0;
        abort = 1'b1; step_clk(); abort = 1'b0;

        // Randomised traffic against the reference
        for (int j = 0; j < 3000; j++) begin
            rst   = (($urandom % 500) == 0);
            abort = (($urandom % 60) == 0);
            go    = (($urandom % 20) == 0);
            dir   = 1'($urandom);
            pause = (($urandom % 6) == 0);
            step_clk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
